// File: rtl/pic_ctrl_pkg.sv
// Shared types and constants for the PIC front-end controller.
// Build option: PIC_CTRL_AUTOINIT_EN enables the automatic ICW/OCW1 init sequence.
package pic_ctrl_pkg;

  // Default init words: edge-triggered single PIC with ICW4, vector base 08h,
  // 8086 mode, all IRQ lines masked.
  localparam logic [7:0] ICW1_DEF = 8'h13;
  localparam logic [7:0] ICW2_DEF = 8'h08;
  localparam logic [7:0] ICW4_DEF = 8'h01;
  localparam logic [7:0] OCW1_DEF = 8'hFF;

  typedef enum logic [2:0] {
    INIT_ICW1,
    INIT_ICW2,
    INIT_ICW4,
    INIT_OCW1,
    RUN
  } init_state_t;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    DONE
  } inta_state_t;

endpackage

// File: rtl/pic_inta_seq.sv
// Two-pulse interrupt-acknowledge sequencer. Generates the INTA pulse train,
// captures the vector on the last cycle of the second pulse and strobes it.
// Build option: none (PIC_CTRL_AUTOINIT_EN only affects pic_ctrl).
module pic_inta_seq
  import pic_ctrl_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] pic_data_i,
  output logic       idle_o,
  output logic       inta_o,
  output logic       vector_valid_o,
  output logic [7:0] vector_o
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  inta_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inta_q;
  logic             valid_q;
  logic [7:0]       vector_q;

  // Sequencer state, width counter and registered outputs, all updated together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      inta_q   <= 1'b0;
      valid_q  <= 1'b0;
      vector_q <= 8'h00;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACK1;
            cnt_q   <= '0;
            inta_q  <= 1'b1;
          end
        end
        ACK1: begin
          if (cnt_q == PULSE_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
            inta_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q <= ACK2;
            cnt_q   <= '0;
            inta_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACK2: begin
          if (cnt_q == PULSE_LAST) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            inta_q   <= 1'b0;
            valid_q  <= 1'b1;
            vector_q <= pic_data_i;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          inta_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idle_o         = (state_q == IDLE);
  assign inta_o         = inta_q;
  assign vector_valid_o = valid_q;
  assign vector_o       = vector_q;

endmodule

// File: rtl/pic_ctrl.sv
// PIC front-end: forwards CPU register writes to the PIC, runs the INTA
// handshake on request and gates the PIC interrupt toward the CPU.
// Build option: define PIC_CTRL_AUTOINIT_EN to have the block program the PIC
// (ICW1, ICW2, ICW4, OCW1) itself after reset; otherwise software does it.
module pic_ctrl
  import pic_ctrl_pkg::*;
#(
  parameter logic [7:0] ICW1    = ICW1_DEF,
  parameter logic [7:0] ICW2    = ICW2_DEF,
  parameter logic [7:0] ICW4    = ICW4_DEF,
  parameter logic [7:0] OCW1    = OCW1_DEF,
  parameter int         PULSE_W = 2,
  parameter int         GAP_W   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpu_wr_i,
  input  logic       cpu_a0_i,
  input  logic [7:0] cpu_data_i,
  output logic       cpu_busy_o,
  input  logic       ack_req_i,
  output logic       vector_valid_o,
  output logic [7:0] vector_o,
  output logic       irq_o,
  output logic       pic_wr_o,
  output logic       pic_a0_o,
  output logic [7:0] pic_data_o,
  output logic       pic_inta_o,
  input  logic       pic_int_i,
  input  logic [7:0] pic_data_i
);

  logic       busy;
  logic       in_run;
  logic       inta_start;
  logic       inta_idle;
  logic       wr_q, wr_d;
  logic       a0_q, a0_d;
  logic [7:0] data_q, data_d;

`ifdef PIC_CTRL_AUTOINIT_EN
  init_state_t init_q;
  logic        pend_q, pend_d;
  logic        run_next;
  logic        init_drv;
  logic [7:0]  init_data;

  // Init sequencer: one PIC register per cycle, then park in RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_q <= INIT_ICW1;
    end else begin
      case (init_q)
        INIT_ICW1: init_q <= INIT_ICW2;
        INIT_ICW2: init_q <= INIT_ICW4;
        INIT_ICW4: init_q <= INIT_OCW1;
        default:   init_q <= RUN;
      endcase
    end
  end

  assign busy     = (init_q != RUN);
  assign in_run   = (init_q == RUN);
  // Starting from OCW1 lets a request held over from init reach ACK1 in the first RUN cycle.
  assign run_next = in_run || (init_q == INIT_OCW1);
  assign inta_start = (ack_req_i | pend_q) & run_next;

  // Remember an acknowledge request seen while the PIC is still being programmed.
  always_comb begin
    pend_d = pend_q;
    if (inta_start && inta_idle) begin
      pend_d = 1'b0;
    end else if (ack_req_i && busy) begin
      pend_d = 1'b1;
    end
  end

  // Pending-request flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Init word for the current state.
  always_comb begin
    init_data = OCW1;
    case (init_q)
      INIT_ICW1: init_data = ICW1;
      INIT_ICW2: init_data = ICW2;
      INIT_ICW4: init_data = ICW4;
      default:   init_data = OCW1;
    endcase
  end

  // Init words go out in the state's own cycle; held off while reset is asserted.
  assign init_drv   = busy & ~rst_i;
  assign pic_wr_o   = init_drv | wr_q;
  assign pic_a0_o   = init_drv ? (init_q != INIT_ICW1) : a0_q;
  assign pic_data_o = init_drv ? init_data : data_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ICW1, ICW2, ICW4, OCW1};

  assign busy       = 1'b0;
  assign in_run     = 1'b1;
  assign inta_start = ack_req_i;
  assign pic_wr_o   = wr_q;
  assign pic_a0_o   = a0_q;
  assign pic_data_o = data_q;
`endif

  assign cpu_busy_o = busy;

  // Accept a CPU write only when not busy; keep the last address/data otherwise.
  always_comb begin
    wr_d   = cpu_wr_i & ~busy;
    a0_d   = a0_q;
    data_d = data_q;
    if (wr_d) begin
      a0_d   = cpu_a0_i;
      data_d = cpu_data_i;
    end
  end

  // CPU write pipeline register toward the PIC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= 1'b0;
      a0_q   <= 1'b0;
      data_q <= 8'h00;
    end else begin
      wr_q   <= wr_d;
      a0_q   <= a0_d;
      data_q <= data_d;
    end
  end

  pic_inta_seq #(
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W)
  ) u_inta_seq (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (inta_start),
    .pic_data_i    (pic_data_i),
    .idle_o        (inta_idle),
    .inta_o        (pic_inta_o),
    .vector_valid_o(vector_valid_o),
    .vector_o      (vector_o)
  );

  // The CPU only sees the PIC interrupt when no acknowledge is in flight.
  assign irq_o = pic_int_i & in_run & inta_idle & ~rst_i;

endmodule

// File: tb/tb_pic_ctrl.sv
// Scoreboard bench for pic_ctrl. Expected PIC writes and vectors are queued
// when stimulus is driven and checked when the DUT produces them.
// Works with or without PIC_CTRL_AUTOINIT_EN defined.
module tb_pic_ctrl;

  localparam int PW  = 2;
  localparam int GW  = 2;
  localparam int LAT = 2 * PW + GW + 1;

  typedef struct {
    int         cyc;
    logic       a0;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int         base;
    logic [7:0] vec;
  } vec_t;

  logic       clk;
  logic       rst_i;
  logic       cpu_wr_i;
  logic       cpu_a0_i;
  logic [7:0] cpu_data_i;
  logic       cpu_busy_o;
  logic       ack_req_i;
  logic       vector_valid_o;
  logic [7:0] vector_o;
  logic       irq_o;
  logic       pic_wr_o;
  logic       pic_a0_o;
  logic [7:0] pic_data_o;
  logic       pic_inta_o;
  logic       pic_int_i;
  logic [7:0] pic_data_i;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 0;
  bit   chk_inta = 1;
  wr_t  wq[$];
  vec_t bq[$];
  wr_t  mon_w;
  vec_t mon_v;
  int   mon_d;
  logic mon_exp;

  pic_ctrl #(
    .PULSE_W(PW),
    .GAP_W  (GW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cpu_wr_i      (cpu_wr_i),
    .cpu_a0_i      (cpu_a0_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_busy_o    (cpu_busy_o),
    .ack_req_i     (ack_req_i),
    .vector_valid_o(vector_valid_o),
    .vector_o      (vector_o),
    .irq_o         (irq_o),
    .pic_wr_o      (pic_wr_o),
    .pic_a0_o      (pic_a0_o),
    .pic_data_o    (pic_data_o),
    .pic_inta_o    (pic_inta_o),
    .pic_int_i     (pic_int_i),
    .pic_data_i    (pic_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int c, input logic a0, input logic [7:0] d);
    wr_t w;
    w.cyc = c;
    w.a0  = a0;
    w.d   = d;
    wq.push_back(w);
  endtask

  task automatic push_vec(input int base, input logic [7:0] v);
    vec_t e;
    e.base = base;
    e.vec  = v;
    bq.push_back(e);
  endtask

  task automatic release_rst();
    rst_i = 1'b0;
`ifdef PIC_CTRL_AUTOINIT_EN
    push_wr(cyc,     1'b0, 8'h13);
    push_wr(cyc + 1, 1'b1, 8'h08);
    push_wr(cyc + 2, 1'b1, 8'h01);
    push_wr(cyc + 3, 1'b1, 8'hFF);
`endif
  endtask

  // One-cycle CPU write; the PIC sees it on the following cycle.
  task automatic cpu_write(input logic a0, input logic [7:0] d);
    cpu_wr_i   = 1'b1;
    cpu_a0_i   = a0;
    cpu_data_i = d;
    push_wr(cyc + 1, a0, d);
    step(1);
    cpu_wr_i = 1'b0;
  endtask

  // One-cycle acknowledge request with the vector the PIC will return.
  task automatic ack_pulse(input logic [7:0] v);
    ack_req_i = 1'b1;
    push_vec(cyc, v);
    step(1);
    ack_req_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (bq.size() != 0 || wq.size() != 0); i++) step(1);
    chk("drain_vec", bq.size(), 0);
    chk("drain_wr", wq.size(), 0);
  endtask

  // Output monitor: INTA waveform, vector strobes and PIC writes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_inta) begin
        mon_exp = 1'b0;
        if (bq.size() > 0) begin
          mon_d   = cyc - bq[0].base;
          mon_exp = (mon_d >= 1 && mon_d <= PW) || (mon_d >= PW + GW + 1 && mon_d <= 2 * PW + GW);
        end
        chk("inta", pic_inta_o, mon_exp);
      end
      if (vector_valid_o) begin
        if (bq.size() == 0) begin
          chk("vld_unexp", 1, 0);
        end else begin
          mon_v = bq.pop_front();
          $display("vec cyc=%0d vector=%02h", cyc, vector_o);
          chk("vld_lat", cyc - mon_v.base, LAT);
          chk("vector", vector_o, mon_v.vec);
        end
      end
      if (pic_wr_o) begin
        if (wq.size() == 0) begin
          chk("wr_unexp", 1, 0);
        end else begin
          mon_w = wq.pop_front();
          $display("wr cyc=%0d a0=%0d data=%02h", cyc, pic_a0_o, pic_data_o);
          chk("wr_cyc", cyc, mon_w.cyc);
          chk("wr_a0", pic_a0_o, mon_w.a0);
          chk("wr_data", pic_data_o, mon_w.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    rst_i      = 1'b1;
    cpu_wr_i   = 1'b0;
    cpu_a0_i   = 1'b0;
    cpu_data_i = 8'h00;
    ack_req_i  = 1'b0;
    pic_int_i  = 1'b1;
    pic_data_i = 8'h00;
    step(2);

    // Reset values (pic_int_i held high to show irq_o is gated)
    chk("rst_wr", pic_wr_o, 0);
    chk("rst_a0", pic_a0_o, 0);
    chk("rst_data", pic_data_o, 0);
    chk("rst_inta", pic_inta_o, 0);
    chk("rst_vld", vector_valid_o, 0);
    chk("rst_vec", vector_o, 0);
    chk("rst_irq", irq_o, 0);
`ifdef PIC_CTRL_AUTOINIT_EN
    chk("rst_busy", cpu_busy_o, 1);
`else
    chk("rst_busy", cpu_busy_o, 0);
`endif
    mon_en = 1;
    release_rst();

`ifdef PIC_CTRL_AUTOINIT_EN
    // Init sequence, request latched in the 2nd init cycle, write dropped in OCW1
    r = cyc;
    chk("busy_init", cpu_busy_o, 1);
    step(1);
    pic_data_i = 8'h0F;
    ack_req_i  = 1'b1;
    push_vec(r + 3, 8'h0F);
    chk("irq_init", irq_o, 0);
    step(1);
    ack_req_i = 1'b0;
    step(1);
    cpu_wr_i   = 1'b1;
    cpu_a0_i   = 1'b1;
    cpu_data_i = 8'h55;
    chk("busy_ocw1", cpu_busy_o, 1);
    chk("irq_ocw1", irq_o, 0);
    step(1);
    cpu_wr_i = 1'b0;
    chk("busy_run", cpu_busy_o, 0);
    chk("irq_pend_ack", irq_o, 0);
    step(2);
    chk("irq_pend_ack2", irq_o, 0);
    drain();
`else
    chk("busy_run", cpu_busy_o, 0);
`endif

    // irq_o follows pic_int_i while idle in RUN
    pic_int_i = 1'b1;
    #1;
    chk("irq_idle_hi", irq_o, 1);
    pic_int_i = 1'b0;
    #1;
    chk("irq_idle_lo", irq_o, 0);
    step(1);

    // Basic acknowledge at default timing
    pic_int_i  = 1'b1;
    pic_data_i = 8'h0B;
    ack_pulse(8'h0B);
    chk("irq_in_ack", irq_o, 0);
    step(3);
    chk("irq_in_gap", irq_o, 0);
    drain();
    chk("irq_after", irq_o, 1);

    // Plain write forwarding, back to back
    cpu_write(1'b0, 8'hA5);
    cpu_write(1'b1, 8'h3C);
    cpu_write(1'b1, 8'h00);
    drain();

    // CPU write during GAP leaves INTA timing alone
    pic_data_i = 8'h5A;
    k = cyc;
    ack_pulse(8'h5A);
    step(2);
    chk("gap_cyc", cyc - k, 3);
    cpu_write(1'b1, 8'hFE);
    drain();

    // Held request restarts right after DONE; spurious (pic_int_i low) still runs
    pic_int_i  = 1'b0;
    pic_data_i = 8'h21;
    k = cyc;
    ack_req_i = 1'b1;
    push_vec(k, 8'h21);
    push_vec(k + LAT + 1, 8'h47);
    step(LAT + 1);
    pic_data_i = 8'h47;
    step(1);
    ack_req_i = 1'b0;
    drain();
    step(5);
    chk("vec_hold", vector_o, 8'h47);

    // Reset in ACK2
    chk_inta   = 0;
    pic_data_i = 8'h99;
    ack_req_i  = 1'b1;
    step(1);
    ack_req_i = 1'b0;
    step(4);
    chk("ack2_inta", pic_inta_o, 1);
    rst_i = 1'b1;
    step(1);
    chk("rst_ack2_inta", pic_inta_o, 0);
    chk("rst_ack2_vld", vector_valid_o, 0);
`ifdef PIC_CTRL_AUTOINIT_EN
    chk("rst_ack2_busy", cpu_busy_o, 1);
`endif
    step(1);
    release_rst();
    step(12);
    chk("rst_ack2_vec", vector_o, 0);
    chk_inta = 1;
    drain();

    // One more acknowledge after the reset
    pic_data_i = 8'h0F;
    ack_pulse(8'h0F);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pic_ctrl.md
PIC_CTRL -- requirements
Module: pic_ctrl

Interface
REQ-001 SHALL have parameter ICW1, default 8'h13, meaning edge-triggered, single, ICW4 needed.
REQ-002 SHALL have parameter ICW2, default 8'h08, meaning vector base.
REQ-003 SHALL have parameter ICW4, default 8'h01, meaning 8086 mode.
REQ-004 SHALL have parameter OCW1, default 8'hFF, meaning initial IRQ mask.
REQ-005 SHALL have parameter PULSE_W, default 2, meaning the INTA pulse width in cycles (>=1).
REQ-006 SHALL have parameter GAP_W, default 2, meaning the gap between INTA pulses in cycles (>=1).
REQ-007 SHALL use one clock; reset is synchronous and active-high; ports clk_i and rst_i, each input, 1 bit.
REQ-008 SHALL have ports:
- cpu_wr_i in 1, cpu_a0_i in 1, cpu_data_i in 8: CPU register write toward the PIC.
- cpu_busy_o out 1: writes ignored while high.
- ack_req_i in 1: CPU interrupt-acknowledge request.
- vector_valid_o out 1: one-cycle vector strobe.
- vector_o out 8: captured vector.
- irq_o out 1: interrupt to the CPU.
- pic_wr_o out 1, pic_a0_o out 1, pic_data_o out 8: PIC write port.
- pic_inta_o out 1: PIC acknowledge.
- pic_int_i in 1: PIC interrupt output.
- pic_data_i in 8: PIC data output.

Function
REQ-009 SHALL run the init FSM INIT_ICW1 -> INIT_ICW2 -> INIT_ICW4 -> INIT_OCW1 -> RUN, advancing one state per cycle.
REQ-010 SHALL drive the following in each init state: pic_wr_o=1; pic_a0_o = 0 for ICW1, 1 otherwise; pic_data_o = the matching parameter. ICW3 SHALL NOT be written.
REQ-011 SHALL hold cpu_busy_o=1 in every init state, drop it in the first RUN cycle, and discard cpu_wr_i while busy, including in the final init cycle.
REQ-012 In RUN, SHALL register cpu_wr_i/a0/data onto pic_wr_o/a0/data with 1-cycle latency, pic_wr_o high for exactly one cycle per accepted write.
REQ-013 SHALL run the INTA FSM IDLE -> ACK1 (PULSE_W) -> GAP (GAP_W) -> ACK2 (PULSE_W) -> DONE (1) -> IDLE; pic_inta_o=1 only in ACK1/ACK2.
REQ-014 SHALL, on ack_req_i high in IDLE with the init FSM in RUN, enter ACK1 on the next cycle.
REQ-015 SHALL capture pic_data_i into vector_o on the last ACK2 cycle and assert vector_valid_o in DONE; vector_o SHALL hold until the next capture.
REQ-016 Latency: vector_valid_o SHALL occur 2*PULSE_W+GAP_W+1 cycles after the ack_req_i sampling edge.
REQ-017 SHALL ignore ack_req_i outside IDLE; a level still high in the cycle after DONE SHALL start a new sequence.
REQ-018 SHALL latch an ack_req_i pulse arriving during init as pending and service it in the first RUN cycle.
REQ-019 SHALL drive irq_o = pic_int_i AND (init FSM in RUN) AND (INTA FSM in IDLE).
REQ-020 SHALL process CPU writes concurrently with an INTA sequence; the two FSMs SHALL be independent.
REQ-021 SHALL run the INTA sequence even if pic_int_i is low, returning whatever the PIC drives (spurious IR7 vector).

Reset
REQ-022 On rst_i: SHALL put the init FSM in INIT_ICW1 (macro on) or RUN (macro off), the INTA FSM in IDLE, and clear the pending flag.
REQ-023 Reset output values SHALL be: pic_wr_o=0, pic_a0_o=0, pic_data_o=0, pic_inta_o=0, vector_valid_o=0, vector_o=0, irq_o=0. cpu_busy_o SHALL be 1 with the macro and 0 without it.
REQ-024 Reset mid-INTA SHALL drop pic_inta_o on the next edge; no vector_valid_o SHALL be produced.

Configuration
REQ-025 Macro PIC_CTRL_AUTOINIT_EN: when defined, REQ-009..011 and REQ-018 SHALL apply. When undefined, the init FSM and ICW/OCW1 logic SHALL be absent, the block SHALL start in RUN, cpu_busy_o SHALL be tied 0, and software SHALL program the PIC.

Structure
REQ-026 Package pic_ctrl_pkg SHALL hold the init and INTA state enums and the ICW1/ICW2/ICW4/OCW1 default constants.
REQ-027 The INTA FSM plus width counter SHALL be sub-module pic_inta_seq; the init FSM and write muxing SHALL stay in pic_ctrl.

Verification
REQ-028 Reset release with the macro on SHALL give pic_wr_o on 4 consecutive cycles with (a0,data) = (0,13), (1,08), (1,01), (1,FF), then cpu_busy_o=0.
REQ-029 pic_data_i=8'h0B with ack_req_i pulsed in RUN at defaults SHALL give pic_inta_o high on cycles 1-2 and 5-6, then vector_valid_o on cycle 7 with vector_o=8'h0B.
REQ-030 ack_req_i pulsed in the 2nd init cycle SHALL start ACK1 on the cycle after INIT_OCW1, and irq_o SHALL stay 0 throughout.
REQ-031 cpu_wr_i (a0=1, data=8'hFE) during GAP SHALL give pic_wr_o 1 cycle later with inta timing unchanged.
REQ-032 rst_i in ACK2 SHALL give pic_inta_o=0 next cycle, no vector_valid_o, and the init sequence restarting (macro on).
